la_ioinput_filt: RTL and testbench



---
 rtl/la_iolib_pkg.sv | 21 ++
 rtl/la_ioinput_filt_chan.sv | 77 +++++++
 rtl/la_ioinput_filt.sv | 90 +++++++++
 tb/tb_la_ioinput_filt.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/la_iolib_pkg.sv
// Shared IO-library definitions: ring side encodings, irq_en bit positions
// and the filter counter width helper.
package la_iolib_pkg;

  typedef enum logic [1:0] {
    SIDE_NO = 2'd0,
    SIDE_SO = 2'd1,
    SIDE_EA = 2'd2,
    SIDE_WE = 2'd3
  } side_t;

  // Bit offsets inside each channel's 2-bit irq_en field
  localparam int unsigned RISE = 0;
  localparam int unsigned FALL = 1;

  // Counter must hold 0..FILTER-1; a bypassed filter still gets a legal 1-bit width
  function automatic int unsigned cnt_width(input int unsigned filter);
    return (filter == 0) ? 1 : $clog2(filter + 1);
  endfunction

endpackage

// File: rtl/la_ioinput_filt_chan.sv
// Single input channel: SYNC-flop synchroniser, stability filter and
// registered rise/fall edge pulses.
module la_ioinput_filt_chan
  import la_iolib_pkg::*;
#(
  parameter int unsigned SYNC   = 2,
  parameter int unsigned FILTER = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic g,
  output logic z,
  output logic rise,
  output logic fall
);

  logic [SYNC-1:0] sync_q;
  logic            s;
  logic            q;
  logic            q_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC-2:0], g};
  end

  assign s = sync_q[SYNC-1];

  if (FILTER == 0) begin : g_bypass
    // Last synchroniser stage doubles as the stable value, so a step lands
    // SYNC edges after it is first sampled.
    assign q     = s;
    assign q_nxt = sync_q[SYNC-2];
  end else begin : g_filter
    localparam int unsigned CW = cnt_width(FILTER);

    logic          q_r;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;

    // Any sample that agrees with q restarts the count, rejecting short glitches
    always_comb begin
      q_nxt   = q_r;
      cnt_nxt = '0;
      if (s != q_r) begin
        if (cnt_q == CW'(FILTER - 1)) q_nxt = s;
        else                          cnt_nxt = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        q_r   <= 1'b0;
        cnt_q <= '0;
      end else begin
        q_r   <= q_nxt;
        cnt_q <= cnt_nxt;
      end
    end

    assign q = q_r;
  end

  // Edge pulses are registered alongside q, so they coincide with the new z level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= q_nxt & ~q;
      fall <= ~q_nxt & q;
    end
  end

  assign z = q;

endmodule

// File: rtl/la_ioinput_filt.sv
// Multi-channel filtered digital input cell with ie gating and optional
// sticky edge interrupts (enabled by defining LA_IOINPUT_IRQ_EN).
module la_ioinput_filt
  import la_iolib_pkg::*;
#(
  parameter string       PROP   = "DEFAULT",
  parameter string       SIDE   = "NO",
  parameter int unsigned N      = 4,
  parameter int unsigned SYNC   = 2,
  parameter int unsigned FILTER = 3,
  parameter int unsigned CFGW   = 16,
  parameter int unsigned RINGW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [N-1:0]      pad,
  inout  wire               vdd,
  inout  wire               vss,
  inout  wire               vddio,
  inout  wire               vssio,
  input  logic [N-1:0]      ie,
  output logic [N-1:0]      z,
  output logic [N-1:0]      rise,
  output logic [N-1:0]      fall,
  input  logic [2*N-1:0]    irq_en,
  input  logic [N-1:0]      irq_clr,
  output logic [N-1:0]      irq_status,
  output logic              irq,
  inout  wire  [RINGW-1:0]  ioring,
  input  logic [N*CFGW-1:0] cfg
);

  localparam side_t RING_SIDE = (SIDE == "SO") ? SIDE_SO :
                                (SIDE == "EA") ? SIDE_EA :
                                (SIDE == "WE") ? SIDE_WE : SIDE_NO;
  localparam bit    PROP_DEFAULT = (PROP == "DEFAULT");

  logic [N-1:0] g;

  // Disabled channels feed a constant 0 through the same sync/filter path
  assign g = ie & pad;

  for (genvar i = 0; i < N; i++) begin : g_chan
    la_ioinput_filt_chan #(
      .SYNC   (SYNC),
      .FILTER (FILTER)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .g     (g[i]),
      .z     (z[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

`ifdef LA_IOINPUT_IRQ_EN
  logic [N-1:0] irq_set;

  always_comb begin
    irq_set = '0;
    for (int i = 0; i < int'(N); i++) begin
      irq_set[i] = (rise[i] & irq_en[2*i + int'(RISE)]) |
                   (fall[i] & irq_en[2*i + int'(FALL)]);
    end
  end

  // Set has priority over a coincident clear so no edge is ever lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_status <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~irq_clr) | irq_set;
      irq        <= |irq_status;
    end
  end

  logic unused_pins;
  assign unused_pins = ^{vdd, vss, vddio, vssio, ioring, cfg, RING_SIDE, PROP_DEFAULT};
`else
  assign irq_status = '0;
  assign irq        = 1'b0;

  logic unused_pins;
  assign unused_pins = ^{vdd, vss, vddio, vssio, ioring, cfg, RING_SIDE, PROP_DEFAULT,
                         irq_en, irq_clr};
`endif

endmodule

// File: tb/tb_la_ioinput_filt.sv
// Bench for la_ioinput_filt: a filtered build and a bypass build checked every
// cycle against a sample-history reference model.
module tb_la_ioinput_filt;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pad_drv;
  logic [3:0]  ie;
  logic [7:0]  irq_en;
  logic [3:0]  irq_clr;
  logic [63:0] cfg;

  wire  [3:0]  pad;
  wire         vdd, vss, vddio, vssio;
  wire  [7:0]  ioring;

  assign pad    = pad_drv;
  assign vdd    = 1'b1;
  assign vss    = 1'b0;
  assign vddio  = 1'b1;
  assign vssio  = 1'b0;
  assign ioring = 8'h00;

  logic [3:0] z_a, rise_a, fall_a, stat_a;
  logic       irq_a;
  logic [3:0] z_b, rise_b, fall_b, stat_b;
  logic       irq_b;

  la_ioinput_filt #(.N(4), .SYNC(2), .FILTER(3)) dut_a (
    .clk(clk), .reset(reset), .pad(pad), .vdd(vdd), .vss(vss), .vddio(vddio),
    .vssio(vssio), .ie(ie), .z(z_a), .rise(rise_a), .fall(fall_a), .irq_en(irq_en),
    .irq_clr(irq_clr), .irq_status(stat_a), .irq(irq_a), .ioring(ioring), .cfg(cfg)
  );

  la_ioinput_filt #(.N(4), .SYNC(3), .FILTER(0)) dut_b (
    .clk(clk), .reset(reset), .pad(pad), .vdd(vdd), .vss(vss), .vddio(vddio),
    .vssio(vssio), .ie(ie), .z(z_b), .rise(rise_b), .fall(fall_b), .irq_en(irq_en),
    .irq_clr(irq_clr), .irq_status(stat_b), .irq(irq_b), .ioring(ioring), .cfg(cfg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: history of gated samples (index 0 = newest edge)
  logic [3:0] gh[$];
  int         msync[2] = '{2, 3};
  int         mfilt[2] = '{3, 0};
  logic [3:0] mq[2], mr[2], mf[2], ms[2];
  logic       mi[2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    gh = {};
    for (int k = 0; k < 16; k++) gh.push_front(4'h0);
    for (int d = 0; d < 2; d++) begin
      mq[d] = 4'h0; mr[d] = 4'h0; mf[d] = 4'h0; ms[d] = 4'h0; mi[d] = 1'b0;
    end
  endtask

  // A level is accepted once the last FILTER synchronised samples all disagree with it
  function automatic logic [3:0] next_q(input int d);
    logic [3:0] nq;
    bit         flip;
    for (int c = 0; c < 4; c++) begin
      if (mfilt[d] == 0) begin
        nq[c] = gh[msync[d]-1][c];
      end else begin
        flip = 1'b1;
        for (int k = msync[d]; k < msync[d] + mfilt[d]; k++)
          if (gh[k][c] == mq[d][c]) flip = 1'b0;
        nq[c] = flip ? ~mq[d][c] : mq[d][c];
      end
    end
    return nq;
  endfunction

  task automatic check_all();
    chk("z_a", {4'h0, z_a}, {4'h0, mq[0]});
    chk("rise_a", {4'h0, rise_a}, {4'h0, mr[0]});
    chk("fall_a", {4'h0, fall_a}, {4'h0, mf[0]});
    chk("stat_a", {4'h0, stat_a}, {4'h0, ms[0]});
    chk("irq_a", {7'h0, irq_a}, {7'h0, mi[0]});
    chk("z_b", {4'h0, z_b}, {4'h0, mq[1]});
    chk("rise_b", {4'h0, rise_b}, {4'h0, mr[1]});
    chk("fall_b", {4'h0, fall_b}, {4'h0, mf[1]});
    chk("stat_b", {4'h0, stat_b}, {4'h0, ms[1]});
    chk("irq_b", {7'h0, irq_b}, {7'h0, mi[1]});
  endtask

  task automatic step();
    logic [3:0] g_now, clr_now, nq, set;
    logic [7:0] en_now;
    logic       rst_now;
    g_now   = ie & pad_drv;
    en_now  = irq_en;
    clr_now = irq_clr;
    rst_now = reset;
    @(posedge clk);
    gh.push_front(rst_now ? 4'h0 : g_now);
    void'(gh.pop_back());
    for (int d = 0; d < 2; d++) begin
      if (rst_now) begin
        mq[d] = 4'h0; mr[d] = 4'h0; mf[d] = 4'h0; ms[d] = 4'h0; mi[d] = 1'b0;
      end else begin
        nq = next_q(d);
        for (int c = 0; c < 4; c++)
          set[c] = (mr[d][c] & en_now[2*c]) | (mf[d][c] & en_now[2*c+1]);
`ifdef LA_IOINPUT_IRQ_EN
        mi[d] = |ms[d];
        ms[d] = (ms[d] & ~clr_now) | set;
`else
        mi[d] = 1'b0;
        ms[d] = 4'h0;
`endif
        mr[d] = nq & ~mq[d];
        mf[d] = ~nq & mq[d];
        mq[d] = nq;
      end
    end
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    model_clear();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; pad_drv = 4'h0; ie = 4'hF; irq_en = 8'h01; irq_clr = 4'h0;
    cfg = 64'h0;
    model_clear();
    #1;
    chk("reset_z", {4'h0, z_a}, 8'h00);
    chk("reset_irq", {7'h0, irq_a}, 8'h00);
    steps(2);

    // Latency: pad[0] step
    reset = 1'b0;
    pad_drv = 4'h1;
    steps(3);
    chk("bypass_lat_z", {4'h0, z_b}, 8'h01);
    steps(1);
    chk("lat_z_before", {4'h0, z_a}, 8'h00);
    steps(1);
    chk("lat_z", {4'h0, z_a}, 8'h01);
    chk("lat_rise", {4'h0, rise_a}, 8'h01);
    steps(1);
    chk("lat_rise_end", {4'h0, rise_a}, 8'h00);
`ifdef LA_IOINPUT_IRQ_EN
    chk("irq_stat_set", {4'h0, stat_a}, 8'h01);
    steps(1);
    chk("irq_lag", {7'h0, irq_a}, 8'h01);
`else
    chk("irq_stat_tied", {4'h0, stat_a}, 8'h00);
    steps(1);
    chk("irq_tied", {7'h0, irq_a}, 8'h00);
`endif

    // Glitch rejection on channel 1, then a 3-cycle pulse that propagates
    pad_drv = 4'h3; steps(2);
    pad_drv = 4'h1; steps(8);
    chk("glitch_z", {4'h0, z_a}, 8'h01);
    pad_drv = 4'h3; steps(3);
    pad_drv = 4'h1; steps(8);

    // Input enable gating
    pad_drv = 4'hF; steps(8);
    chk("ie_settled", {4'h0, z_a}, 8'h0F);
    ie = 4'b0101;
    steps(4);
    chk("ie_z_hold", {4'h0, z_a}, 8'h0F);
    steps(1);
    chk("ie_z", {4'h0, z_a}, 8'h05);
    chk("ie_fall", {4'h0, fall_a}, 8'h0A);
    steps(3);

    // Reset mid-count on channel 2
    ie = 4'hF; pad_drv = 4'h0; steps(8);
    pad_drv = 4'h4; steps(2);
    assert_reset();
    chk("rst_mid_z", {4'h0, z_a}, 8'h00);
    steps(2);
    reset = 1'b0;
    steps(4);
    chk("rst_rel_before", {4'h0, z_a}, 8'h00);
    steps(1);
    chk("rst_rel_z", {4'h0, z_a}, 8'h04);
    chk("rst_rel_rise", {4'h0, rise_a}, 8'h04);

    // Bypass passes a single-cycle pulse
    pad_drv = 4'h0; steps(8);
    pad_drv = 4'h8; steps(1);
    pad_drv = 4'h0; steps(2);
    chk("bypass_pulse", {4'h0, z_b}, 8'h08);
    steps(6);

    // Coincident set and clear keeps status, clear alone drops it
    irq_clr = 4'hF; steps(1);
    irq_clr = 4'h0;
    pad_drv = 4'h1; steps(5);
    irq_clr = 4'h1; steps(1);
`ifdef LA_IOINPUT_IRQ_EN
    chk("set_wins", {4'h0, stat_a}, 8'h01);
`endif
    irq_clr = 4'h0; steps(2);
    irq_clr = 4'h1; steps(1);
    chk("clr_alone", {4'h0, stat_a}, 8'h00);
    irq_clr = 4'h0; steps(2);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(5) == 0) pad_drv[c] = ~pad_drv[c];
      if ($urandom_range(39) == 0) ie = 4'($urandom);
      if ($urandom_range(49) == 0) irq_en = 8'($urandom);
      irq_clr = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(149) == 0) begin
        assert_reset();
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
